hex_msg_writer: RTL and testbench

HEX_MSG_WRITER -- requirements
Module: hex_msg_writer

---
 rtl/hex_msg_writer.sv | 193 +++++++++++++++++++
 tb/tb_hex_msg_writer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_msg_writer.sv
// Push-button message writer for a row of seven-segment displays: keys append
// 3-bit character codes to a small buffer, a switch scrolls the message.
module hex_msg_writer #(
    parameter int NUM_DISP = 8,
    parameter int TICK_DIV = 25000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_key,
    input  logic                     clr_key,
    input  logic                     scroll_en,
    input  logic [2:0]               char_in,
    output logic [NUM_DISP-1:0][6:0] hex_disp,
    output logic [9:0]               ledr
);
    localparam int PW = (NUM_DISP > 1) ? $clog2(NUM_DISP) : 1;
    localparam int CW = $clog2(NUM_DISP + 1);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {LOAD, SCROLL} state_t;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_pipe;
    logic       arst_n;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign arst_n = rst_pipe[1];

    logic [1:0] wr_sync, clr_sync, scr_sync;
    logic       wr_prev, clr_prev;
    logic [1:0] settle;
    logic       wr_pulse, clr_pulse;
    logic       settled;

    // Key edges are ignored until the synchronizers hold real samples, so a key
    // held through reset release does not look like a fresh press.
    assign settled = (settle == 2'd3);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_sync   <= 2'b11;
            clr_sync  <= 2'b11;
            scr_sync  <= 2'b00;
            wr_prev   <= 1'b1;
            clr_prev  <= 1'b1;
            settle    <= 2'd0;
            wr_pulse  <= 1'b0;
            clr_pulse <= 1'b0;
        end else begin
            wr_sync   <= {wr_sync[0], wr_key};
            clr_sync  <= {clr_sync[0], clr_key};
            scr_sync  <= {scr_sync[0], scroll_en};
            wr_prev   <= wr_sync[1];
            clr_prev  <= clr_sync[1];
            if (!settled) settle <= settle + 2'd1;
            wr_pulse  <= settled & wr_prev & ~wr_sync[1];
            clr_pulse <= settled & clr_prev & ~clr_sync[1];
        end
    end

    state_t                     state_q, state_n;
    logic [NUM_DISP-1:0][2:0]   msg_q, msg_n;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_n;
    logic [CW-1:0]              count_q, count_n;
    logic [PW-1:0]              offset_q, offset_n;
    logic [TW-1:0]              tick_q, tick_n;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= LOAD;
            msg_q    <= '1;
            wr_ptr_q <= '0;
            count_q  <= '0;
            offset_q <= '0;
            tick_q   <= '0;
        end else begin
            state_q  <= state_n;
            msg_q    <= msg_n;
            wr_ptr_q <= wr_ptr_n;
            count_q  <= count_n;
            offset_q <= offset_n;
            tick_q   <= tick_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        msg_n    = msg_q;
        wr_ptr_n = wr_ptr_q;
        count_n  = count_q;
        offset_n = offset_q;
        tick_n   = tick_q;
        if (clr_pulse) begin
            state_n  = LOAD;
            msg_n    = '1;
            wr_ptr_n = '0;
            count_n  = '0;
            offset_n = '0;
            tick_n   = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    offset_n = '0;
                    tick_n   = '0;
                    if (wr_pulse && count_q < CW'(NUM_DISP)) begin
                        msg_n[wr_ptr_q] = char_in;
                        wr_ptr_n        = wr_ptr_q + PW'(1);
                        count_n         = count_q + CW'(1);
                    end
                    if (scr_sync[1] && count_q != '0) state_n = SCROLL;
                end
                SCROLL: begin
                    if (!scr_sync[1]) begin
                        state_n  = LOAD;
                        offset_n = '0;
                        tick_n   = '0;
                    end else if (tick_q == TW'(TICK_DIV - 1)) begin
                        tick_n = '0;
                        // Wrap over written entries only.
                        if (CW'(offset_q) + CW'(1) >= count_q) offset_n = '0;
                        else                                     offset_n = offset_q + PW'(1);
                    end else begin
                        tick_n = tick_q + TW'(1);
                    end
                end
                default: state_n = LOAD;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_DISP; k++) begin : g_lane
        hex_lane #(.NUM_DISP(NUM_DISP), .PW(PW), .CW(CW), .K(k)) u_lane (
            .clk    (clk),
            .arst_n (arst_n),
            .msg    (msg_q),
            .offset (offset_q),
            .count  (count_q),
            .seg    (hex_disp[NUM_DISP-1-k])
        );
    end

    logic [3:0] count4;
    assign count4 = 4'(count_q);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) ledr <= '0;
        else         ledr <= {count_q == CW'(NUM_DISP), state_q == SCROLL, 4'b0000, count4};
    end
endmodule

// One display position K (0 = leftmost): picks its buffer entry relative to
// the scroll offset and registers the decoded active-low segments.
module hex_lane #(
    parameter int NUM_DISP = 8,
    parameter int PW       = 3,
    parameter int CW       = 4,
    parameter int K        = 0
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic [NUM_DISP-1:0][2:0] msg,
    input  logic [PW-1:0]            offset,
    input  logic [CW-1:0]            count,
    output logic [6:0]               seg
);
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic [2:0]    code;
    logic          visible;

    assign sum     = {1'b0, offset} + (PW+1)'(K);
    assign idx     = (sum >= (PW+1)'(NUM_DISP)) ? PW'(sum - (PW+1)'(NUM_DISP)) : PW'(sum);
    assign code    = msg[idx];
    assign visible = CW'(K) < count;

    function automatic logic [6:0] decode(input logic [2:0] c);
        case (c)
            3'd0:    decode = 7'b0100001;
            3'd1:    decode = 7'b0000110;
            3'd2:    decode = 7'b1111001;
            3'd3:    decode = 7'b1000000;
            3'd4:    decode = 7'b0100100;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) seg <= 7'h7f;
        else         seg <= visible ? decode(code) : 7'h7f;
    end
endmodule

// File: tb/tb_hex_msg_writer.sv
// Self-checking bench for hex_msg_writer (NUM_DISP=8, TICK_DIV=4) against a
// queue-style message model.
module tb_hex_msg_writer;
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           wr_key = 1'b1;
    logic           clr_key = 1'b1;
    logic           scroll_en = 1'b0;
    logic [2:0]     char_in = 3'd0;
    logic [7:0][6:0] hex_disp;
    logic [9:0]     ledr;

    int checks = 0;
    int errors = 0;

    hex_msg_writer #(.NUM_DISP(8), .TICK_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_key    (wr_key),
        .clr_key   (clr_key),
        .scroll_en (scroll_en),
        .char_in   (char_in),
        .hex_disp  (hex_disp),
        .ledr      (ledr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] code;
        logic [6:0] seg;
    } dec_vec_t;

    // Model: written characters in order, unwritten slots hold blank code 7.
    logic [2:0] m_buf [8];
    int         m_cnt;

    function automatic logic [6:0] seg_of(input logic [2:0] c);
        case (c)
            3'd0:    return 7'b0100001;
            3'd1:    return 7'b0000110;
            3'd2:    return 7'b1111001;
            3'd3:    return 7'b1000000;
            3'd4:    return 7'b0100100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [55:0] exp_hex(input int off);
        logic [55:0] r;
        for (int k = 0; k < 8; k++)
            r[(7-k)*7 +: 7] = (k < m_cnt) ? seg_of(m_buf[(k + off) % 8]) : 7'h7f;
        return r;
    endfunction

    function automatic logic [9:0] exp_ledr(input bit scr);
        return {m_cnt == 8, scr, 4'b0000, 4'(m_cnt)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_buf[i] = 3'd7;
        m_cnt = 0;
    endtask

    task automatic model_write(input logic [2:0] c);
        if (m_cnt < 8) begin
            m_buf[m_cnt] = c;
            m_cnt++;
        end
    endtask

    task automatic press_wr(input logic [2:0] c);
        char_in = c;
        @(negedge clk); wr_key = 1'b0;
        repeat (3) @(negedge clk);
        wr_key = 1'b1;
        repeat (6) @(negedge clk);
        model_write(c);
    endtask

    task automatic press_clr();
        @(negedge clk); clr_key = 1'b0;
        repeat (3) @(negedge clk);
        clr_key = 1'b1;
        repeat (6) @(negedge clk);
        model_clear();
    endtask

    task automatic wait_scroll(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (ledr[8] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: scroll indicator never set within 30 cycles", name);
        end
    endtask

    dec_vec_t dec_tab [8];

    initial begin
        dec_tab[0] = '{3'd0, 7'b0100001};
        dec_tab[1] = '{3'd1, 7'b0000110};
        dec_tab[2] = '{3'd2, 7'b1111001};
        dec_tab[3] = '{3'd3, 7'b1000000};
        dec_tab[4] = '{3'd4, 7'b0100100};
        dec_tab[5] = '{3'd5, 7'b1111111};
        dec_tab[6] = '{3'd6, 7'b1111111};
        dec_tab[7] = '{3'd7, 7'b1111111};
        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_hex", hex_disp, {56{1'b1}});
        check("reset_ledr", ledr, 10'h000);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_hex", hex_disp, {56{1'b1}});

        // "dE2"
        press_wr(3'd0); press_wr(3'd1); press_wr(3'd4);
        check("dE2_hex", hex_disp, exp_hex(0));
        check("dE2_ledr", ledr, 10'h003);

        // Decode table on the leftmost display
        for (int i = 0; i < 8; i++) begin
            press_clr();
            press_wr(dec_tab[i].code);
            check($sformatf("decode_%0d", i), hex_disp[7], dec_tab[i].seg);
            check($sformatf("decode_%0d_rest", i), hex_disp[6:0], {49{1'b1}});
        end

        // Held key produces exactly one write
        press_clr();
        char_in = 3'd2;
        @(negedge clk); wr_key = 1'b0;
        repeat (50) @(negedge clk);
        wr_key = 1'b1;
        repeat (6) @(negedge clk);
        model_write(3'd2);
        check("hold_ledr", ledr, 10'h001);
        check("hold_hex7", hex_disp[7], 7'b1111001);
        check("hold_hex", hex_disp, exp_hex(0));

        // Nine presses into an 8-entry buffer
        press_clr();
        for (int i = 0; i < 8; i++) press_wr(3'($urandom_range(0, 4)));
        press_wr(3'd3);
        check("full_hex", hex_disp, exp_hex(0));
        check("full_ledr", ledr, 10'h208);

        // Scrolling "dE2"
        press_clr();
        press_wr(3'd0); press_wr(3'd1); press_wr(3'd4);
        scroll_en = 1'b1;
        wait_scroll("scroll_enter");
        for (int i = 0; i < 16; i++) begin
            check($sformatf("scroll_hex_%0d", i), hex_disp, exp_hex((i / 4) % 3));
            check($sformatf("scroll_ledr_%0d", i), ledr, 10'h103);
            @(negedge clk);
        end
        scroll_en = 1'b0;
        repeat (6) @(negedge clk);
        check("unscroll_hex", hex_disp, exp_hex(0));
        check("unscroll_ledr", ledr, 10'h003);

        // Clear and write together while scrolling: clear wins
        scroll_en = 1'b1;
        wait_scroll("scroll_enter2");
        char_in = 3'd3;
        clr_key = 1'b0; wr_key = 1'b0;
        repeat (3) @(negedge clk);
        clr_key = 1'b1; wr_key = 1'b1;
        repeat (6) @(negedge clk);
        model_clear();
        check("clrwr_hex", hex_disp, {56{1'b1}});
        check("clrwr_ledr", ledr, 10'h000);
        scroll_en = 1'b0;
        repeat (4) @(negedge clk);

        // Random writes and clears against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 2) press_clr();
            else                          press_wr(3'($urandom_range(0, 7)));
            check($sformatf("rand_hex_%0d", i), hex_disp, exp_hex(0));
            check($sformatf("rand_ledr_%0d", i), ledr, exp_ledr(1'b0));
        end

        // Asynchronous reset mid-scroll with a key held through release
        press_clr();
        press_wr(3'd0); press_wr(3'd1); press_wr(3'd4);
        scroll_en = 1'b1;
        wait_scroll("scroll_enter3");
        repeat (5) @(negedge clk);
        char_in = 3'd1;
        wr_key = 1'b0;
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("async_rst_hex", hex_disp, {56{1'b1}});
        check("async_rst_ledr", ledr, 10'h000);
        scroll_en = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("held_key_ledr", ledr, 10'h000);
        check("held_key_hex", hex_disp, {56{1'b1}});
        wr_key = 1'b1;
        repeat (6) @(negedge clk);
        press_wr(3'd4);
        check("after_rst_write", hex_disp, exp_hex(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
